// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared constants and types for the RISC-V fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  // Next-PC select encodings; 2'b11 is reserved and behaves as sequential.
  localparam logic [1:0] PCSRC_SEQ  = 2'b00;
  localparam logic [1:0] PCSRC_BR   = 2'b01;
  localparam logic [1:0] PCSRC_JALR = 2'b10;

  // addi x0, x0, 0 -- value of the instruction register out of reset.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Fetch state machine encoding.
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_ERR   = 2'd2
  } fetch_state_e;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/fetch_next_pc.sv
`default_nettype none
// ============================================================================
// Module      : fetch_next_pc
// Description : Combinational next-PC adder/mux with fetch alignment check.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_next_pc
  import riscv_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [1:0]  i_pcsrc,
  input  logic [31:0] i_immext,
  input  logic [31:0] i_jalr_target,
  output logic [31:0] o_pc_plus4,
  output logic [31:0] o_target,
  output logic        o_misaligned
);

  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_branch;
  logic [31:0] w_jalr_clr;
  logic [31:0] w_target;

  // All sums wrap modulo 2^32; no overflow is reported.
  assign w_pc_plus4  = i_pc + 32'd4;
  assign w_pc_branch = i_pc + i_immext;
  // JALR drops bit 0 before the alignment check, so only bit 1 can fault.
  assign w_jalr_clr  = i_jalr_target & 32'hFFFF_FFFE;

  // Select the next fetch target; the reserved encoding falls back to pc+4.
  always_comb begin
    w_target = w_pc_plus4;
    case (i_pcsrc)
      PCSRC_BR:   w_target = w_pc_branch;
      PCSRC_JALR: w_target = w_jalr_clr;
      default:    w_target = w_pc_plus4;
    endcase
  end

  assign o_pc_plus4   = w_pc_plus4;
  assign o_target     = w_target;
  assign o_misaligned = |w_target[1:0];

endmodule : fetch_next_pc
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage: PC register, ready/valid imem
//               request, instruction register and next-PC sequencing.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ack,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic [1:0]  pcsrc,
  input  logic [31:0] immext,
  input  logic [31:0] jalr_target,
  output logic        misaligned
);

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_instr;
  logic         r_misaligned;
  // Registered copy of reset: keeps imem_req low while reset is held and
  // for the cycle in which reset is first sampled low.
  logic         r_in_reset;

  logic [31:0]  w_target;
  logic         w_target_misaligned;
  logic [31:0]  w_pc_plus4;
  logic         w_imem_req;

  fetch_next_pc u_next_pc (
    .i_pc          (r_pc),
    .i_pcsrc       (pcsrc),
    .i_immext      (immext),
    .i_jalr_target (jalr_target),
    .o_pc_plus4    (w_pc_plus4),
    .o_target      (w_target),
    .o_misaligned  (w_target_misaligned)
  );

  // Request and valid are decoded purely from registered state.
  assign w_imem_req = (r_state == ST_FETCH) && !r_in_reset;

  // Fetch FSM, PC register and instruction register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_FETCH;
      r_pc         <= RESET_PC;
      r_instr      <= NOP_INSTR;
      r_misaligned <= 1'b0;
      r_in_reset   <= 1'b1;
    end else begin
      r_in_reset <= 1'b0;
      case (r_state)
        ST_FETCH: begin
          // Only a response to an issued request is captured.
          if (w_imem_req && imem_ready) begin
            r_instr <= imem_rdata;
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (instr_ack) begin
            if (!w_target_misaligned) begin
              r_pc    <= w_target;
              r_state <= ST_FETCH;
            end else begin
              r_misaligned <= 1'b1;
              r_state      <= ST_ERR;
            end
          end
        end
        ST_ERR: begin
          r_state <= ST_ERR;
        end
        default: begin
          r_state <= ST_ERR;
        end
      endcase
    end
  end

  assign imem_req    = w_imem_req;
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign instr       = r_instr;
  assign instr_valid = (r_state == ST_HOLD);
  assign misaligned  = r_misaligned;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam logic [31:0] C_RESET_PC = 32'h0000_1000;
  localparam logic [31:0] C_NOP      = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ack;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [1:0]  pcsrc;
  logic [31:0] immext;
  logic [31:0] jalr_target;
  logic        misaligned;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.RESET_PC(C_RESET_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ack   (instr_ack),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .pcsrc       (pcsrc),
    .immext      (immext),
    .jalr_target (jalr_target),
    .misaligned  (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and sample just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Zero-wait memory response for one cycle.
  task automatic fetch_word(input logic [31:0] data);
    imem_ready = 1'b1;
    imem_rdata = data;
    tick();
    imem_ready = 1'b0;
  endtask

  // Retire the held instruction with the given next-PC inputs.
  task automatic ack(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] jt);
    pcsrc       = src;
    immext      = imm;
    jalr_target = jt;
    instr_ack   = 1'b1;
    tick();
    instr_ack   = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_pc"},    pc, C_RESET_PC);
    chk({tag, "_instr"}, instr, C_NOP);
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, "_mis"},   {31'd0, misaligned}, 32'd0);
    chk({tag, "_req"},   {31'd0, imem_req}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; imem_ready = 1'b0; imem_rdata = 32'd0; instr_ack = 1'b0;
    pcsrc = 2'b00; immext = 32'd0; jalr_target = 32'd0;
    tick(); tick();
    chk_reset_state("por");

    // First request after reset release.
    reset = 1'b0; tick();
    chk("req_after_rst", {31'd0, imem_req}, 32'd1);
    chk("addr0", imem_addr, 32'h0000_1000);
    chk("valid_fetch", {31'd0, instr_valid}, 32'd0);

    // Sequential stream with zero-wait memory.
    fetch_word(32'hA000_0000);
    chk("cap0_valid", {31'd0, instr_valid}, 32'd1);
    chk("cap0_instr", instr, 32'hA000_0000);
    chk("cap0_req", {31'd0, imem_req}, 32'd0);
    chk("cap0_p4", pc_plus4, 32'h0000_1004);
    ack(2'b00, 32'd0, 32'd0);
    chk("seq1_addr", imem_addr, 32'h0000_1004);
    chk("seq1_req", {31'd0, imem_req}, 32'd1);
    chk("seq1_valid", {31'd0, instr_valid}, 32'd0);

    // Three wait states: address and instruction held.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wait_req", {31'd0, imem_req}, 32'd1);
      chk("wait_addr", imem_addr, 32'h0000_1004);
      chk("wait_instr", instr, 32'hA000_0000);
    end
    fetch_word(32'hA100_0001);
    chk("cap1_instr", instr, 32'hA100_0001);
    ack(2'b00, 32'd0, 32'd0);
    chk("seq2_addr", imem_addr, 32'h0000_1008);
    fetch_word(32'hA200_0002);
    chk("hold_p4", pc_plus4, 32'h0000_100C);

    // imem_ready in HOLD is ignored.
    imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF; tick(); imem_ready = 1'b0;
    chk("hold_rdy_instr", instr, 32'hA200_0002);
    chk("hold_rdy_valid", {31'd0, instr_valid}, 32'd1);

    // Backward branch.
    ack(2'b01, 32'hFFFF_FFF8, 32'd0);
    chk("br_addr", imem_addr, 32'h0000_1000);
    chk("br_mis", {31'd0, misaligned}, 32'd0);

    // instr_ack in FETCH is ignored.
    instr_ack = 1'b1; pcsrc = 2'b01; immext = 32'h100; tick(); instr_ack = 1'b0;
    chk("fetch_ack_addr", imem_addr, 32'h0000_1000);
    chk("fetch_ack_req", {31'd0, imem_req}, 32'd1);

    // JALR with bit 0 set is legal.
    fetch_word(32'hA300_0003);
    ack(2'b10, 32'd0, 32'h0000_2001);
    chk("jalr_addr", imem_addr, 32'h0000_2000);
    chk("jalr_mis", {31'd0, misaligned}, 32'd0);

    // Reserved pcsrc behaves as sequential.
    fetch_word(32'hA400_0004);
    ack(2'b11, 32'h100, 32'h0000_4000);
    chk("rsvd_addr", imem_addr, 32'h0000_2004);

    // JALR target with bit 1 set traps.
    fetch_word(32'hA500_0005);
    ack(2'b10, 32'd0, 32'h0000_2002);
    chk("jtrap_mis", {31'd0, misaligned}, 32'd1);
    chk("jtrap_req", {31'd0, imem_req}, 32'd0);
    chk("jtrap_valid", {31'd0, instr_valid}, 32'd0);
    chk("jtrap_pc", pc, 32'h0000_2004);

    // ERR ignores ack and ready.
    instr_ack = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h1234_5678; pcsrc = 2'b00;
    tick(); tick();
    instr_ack = 1'b0; imem_ready = 1'b0;
    chk("err_mis", {31'd0, misaligned}, 32'd1);
    chk("err_req", {31'd0, imem_req}, 32'd0);
    chk("err_pc", pc, 32'h0000_2004);
    chk("err_instr", instr, 32'hA500_0005);

    // Reset out of ERR.
    reset = 1'b1; tick();
    chk_reset_state("rst_err");
    reset = 1'b0; tick();

    // PC wrap at the top of the address space.
    fetch_word(32'hB000_0000);
    ack(2'b10, 32'd0, 32'hFFFF_FFFC);
    chk("wrap_pre_addr", imem_addr, 32'hFFFF_FFFC);
    fetch_word(32'hB100_0001);
    chk("wrap_p4", pc_plus4, 32'h0000_0000);
    ack(2'b00, 32'd0, 32'd0);
    chk("wrap_addr", imem_addr, 32'h0000_0000);
    chk("wrap_req", {31'd0, imem_req}, 32'd1);

    // Misaligned branch target traps.
    fetch_word(32'hB200_0002);
    ack(2'b10, 32'd0, 32'h0000_1008);
    chk("pre_br_addr", imem_addr, 32'h0000_1008);
    fetch_word(32'hB300_0003);
    ack(2'b01, 32'h0000_0006, 32'd0);
    chk("btrap_mis", {31'd0, misaligned}, 32'd1);
    chk("btrap_req", {31'd0, imem_req}, 32'd0);
    chk("btrap_valid", {31'd0, instr_valid}, 32'd0);
    chk("btrap_pc", pc, 32'h0000_1008);

    reset = 1'b1; tick();
    chk_reset_state("rst_err2");
    reset = 1'b0; tick();

    // Reset in HOLD discards the held instruction.
    fetch_word(32'hC000_0000);
    chk("c0_valid", {31'd0, instr_valid}, 32'd1);
    reset = 1'b1; tick();
    chk_reset_state("rst_hold");
    reset = 1'b0; tick();
    chk("post_hold_req", {31'd0, imem_req}, 32'd1);

    // Reset in FETCH drops the request.
    reset = 1'b1; tick();
    chk_reset_state("rst_fetch");
    reset = 1'b0; tick();
    chk("post_fetch_req", {31'd0, imem_req}, 32'd1);
    chk("post_fetch_addr", imem_addr, 32'h0000_1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_fetch_unit
`default_nettype wire
